// File: rtl/header_pkg.sv
// rtl/header_pkg.sv - shared header byte constants and generator state encoding
// Purpose: constants and state type used by header_gen and header_detect.
package header_pkg;

    localparam logic [7:0] HDR_BYTE0 = 8'h55;
    localparam logic [7:0] HDR_BYTE1 = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } hdr_state_t;

endpackage

// File: rtl/header_detect.sv
// rtl/header_detect.sv - counts consecutive 0x55/0xD5 header pairs on a byte stream
// Purpose: observes a transmit stream and reports how many complete header
//          pairs the most recent header contained.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   din, din_vld    - observed byte stream and its qualifier
//   pair_cnt        - pairs counted in the current/most recent header
module header_detect
    import header_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic [7:0] pair_cnt
);

    logic       r_in_hdr;
    logic       r_phase;    // 1: a 0x55 was seen, 0xD5 completes the pair
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_hdr <= 1'b0;
            r_phase  <= 1'b0;
            r_cnt    <= 8'd0;
        end else if (din_vld) begin
            if (din == HDR_BYTE0) begin
                // A fresh header, or 0x55 0x55 which breaks the pattern: restart.
                if (!r_in_hdr || r_phase) begin
                    r_cnt <= 8'd0;
                end
                r_in_hdr <= 1'b1;
                r_phase  <= 1'b1;
            end else if (din == HDR_BYTE1 && r_phase) begin
                r_cnt   <= r_cnt + 8'd1;
                r_phase <= 1'b0;
            end else begin
                // Any other byte ends the header; the count is held for readout.
                r_in_hdr <= 1'b0;
                r_phase  <= 1'b0;
            end
        end
    end

    assign pair_cnt = r_cnt;

endmodule

// File: rtl/header_gen.sv
// rtl/header_gen.sv - frame generator: 0x55/0xD5 header pairs, payload pass-through, idle gap
// Purpose: on start, emits HDR_PAIRS header pairs, forwards payload bytes until
//          pl_last, then GAP_CYCLES idle-zero cycles followed by a done pulse.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start                     - frame request, sampled only in IDLE
//   pl_data/pl_valid/pl_last  - payload byte stream, pl_ready accepts it
//   dout, dout_vld            - registered transmit byte stream
//   busy, done                - frame in progress / one-cycle completion pulse
module header_gen
    import header_pkg::*;
#(
    parameter int HDR_PAIRS  = 5,
    parameter int GAP_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    output logic       pl_ready,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(HDR_PAIRS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PAIR_LAST = PW'(HDR_PAIRS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);

    hdr_state_t    r_state, w_state;
    logic [PW-1:0] r_pair, w_pair;
    logic          r_phase, w_phase;   // 1: next header byte is 0xD5
    logic [GW-1:0] r_gap, w_gap;
    logic [7:0]    r_dout, w_dout;
    logic          r_dout_vld, w_dout_vld;
    logic          r_done, w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pair     <= '0;
            r_phase    <= 1'b0;
            r_gap      <= '0;
            r_dout     <= 8'h00;
            r_dout_vld <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pair     <= w_pair;
            r_phase    <= w_phase;
            r_gap      <= w_gap;
            r_dout     <= w_dout;
            r_dout_vld <= w_dout_vld;
            r_done     <= w_done;
        end
    end

    // Output bytes are computed one cycle ahead and registered, so the byte
    // chosen in a state appears on dout during the following cycle. The final
    // 0xD5 is therefore loaded on the HDR->PAYLOAD edge, and the last payload
    // byte on the PAYLOAD->GAP edge.
    always_comb begin
        w_state    = r_state;
        w_pair     = r_pair;
        w_phase    = r_phase;
        w_gap      = r_gap;
        w_dout     = 8'h00;
        w_dout_vld = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state    = ST_HDR;
                    w_dout     = HDR_BYTE0;
                    w_dout_vld = 1'b1;
                    w_pair     = '0;
                    w_phase    = 1'b1;
                end
            end
            ST_HDR: begin
                w_dout_vld = 1'b1;
                if (r_phase) begin
                    w_dout  = HDR_BYTE1;
                    w_phase = 1'b0;
                    if (r_pair == PAIR_LAST) begin
                        w_state = ST_PAYLOAD;
                    end else begin
                        w_pair = r_pair + 1'b1;
                    end
                end else begin
                    w_dout  = HDR_BYTE0;
                    w_phase = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                // pl_ready is high throughout PAYLOAD, so pl_valid alone marks a transfer.
                if (pl_valid) begin
                    w_dout     = pl_data;
                    w_dout_vld = 1'b1;
                    if (pl_last) begin
                        w_state = ST_GAP;
                        w_gap   = '0;
                    end
                end
            end
            ST_GAP: begin
                // First GAP cycle still shows the last payload byte, hence the
                // count runs to GAP_CYCLES to produce GAP_CYCLES zero cycles.
                if (r_gap == GAP_LAST) begin
                    w_state = ST_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign pl_ready = (r_state == ST_PAYLOAD);
    assign busy     = (r_state != ST_IDLE);
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign done     = r_done;

endmodule

// File: tb/tb_header_gen.sv
// tb/tb_header_gen.sv - directed self-checking bench for header_gen and header_detect
module tb_header_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       start0, start1;

    logic       rdy0, vld0, busy0, done0;
    logic       rdy1, vld1, busy1, done1;
    logic [7:0] dout0, dout1;
    logic [7:0] pair_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] obs[$];
    logic [10:0] exp_q[$];
    logic [9:0]  pq[$];     // {last, stall, byte}

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    header_gen u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start0),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_last  (pl_last),
        .pl_ready (rdy0),
        .dout     (dout0),
        .dout_vld (vld0),
        .busy     (busy0),
        .done     (done0)
    );

    header_gen #(.HDR_PAIRS(1), .GAP_CYCLES(1)) u_dut_min (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_last  (pl_last),
        .pl_ready (rdy1),
        .dout     (dout1),
        .dout_vld (vld1),
        .busy     (busy1),
        .done     (done1)
    );

    header_detect u_det (
        .clk      (clk),
        .rst      (rst),
        .din      (dout0),
        .din_vld  (vld0),
        .pair_cnt (pair_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, dout_vld, dout} of the selected instance
    function automatic logic [10:0] cur();
        if (sel) return {busy1, done1, vld1, dout1};
        return {busy0, done0, vld0, dout0};
    endfunction

    function automatic logic cur_rdy();
        return sel ? rdy1 : rdy0;
    endfunction

    task automatic drive_pl();
        if (pq.size() > 0) begin
            pl_valid = ~pq[0][8];
            pl_data  = pq[0][7:0];
            pl_last  = pq[0][9];
            if (cur_rdy()) void'(pq.pop_front());
        end else begin
            pl_valid = 1'b0;
            pl_last  = 1'b0;
            pl_data  = 8'h00;
        end
    endtask

    task automatic run_frame(input int ncyc, input int s_a, input int s_b, input int r_at, input bit b2b);
        bit restarted;
        logic [10:0] o;
        restarted = 1'b0;
        obs.delete();
        start = 1'b1;
        drive_pl();
        tick();
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            o = cur();
            obs.push_back(o);
            start = (c == s_a) || (c == s_b);
            if (b2b && o[9] && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            rst = (c == r_at);
            drive_pl();
            tick();
        end
        start    = 1'b0;
        rst      = 1'b0;
        pl_valid = 1'b0;
        pl_last  = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        check_val({tag, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check_val($sformatf("%s[%0d]", tag, i), obs[i], exp_q[i]);
    endtask

    task automatic e_hdr(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(11'h555);
            exp_q.push_back(11'h5D5);
        end
    endtask
    task automatic e_pl(input logic [7:0] b);
        exp_q.push_back({3'b101, b});
    endtask
    task automatic e_zero(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(11'h400);
    endtask
    task automatic e_done();
        exp_q.push_back(11'h200);
    endtask
    task automatic e_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(11'h000);
    endtask

    task automatic basic_expect();
        exp_q.delete();
        e_hdr(5); e_pl(8'hA1); e_pl(8'hA2); e_pl(8'hA3); e_zero(2); e_done(); e_idle(2);
    endtask

    task automatic load_basic();
        pq.delete();
        pq.push_back(10'h0A1); pq.push_back(10'h0A2); pq.push_back(10'h2A3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0;
        pl_data = 8'h00; pl_valid = 1'b0; pl_last = 1'b0;
        tick();
        tick();
        check_val("rst_dout",  dout0, 8'h00);
        check_val("rst_vld",   vld0,  1'b0);
        check_val("rst_busy",  busy0, 1'b0);
        check_val("rst_done",  done0, 1'b0);
        check_val("rst_ready", rdy0,  1'b0);
        check_val("rst_busy_min", busy1, 1'b0);
        rst = 1'b0;
        tick();

        // basic frame
        load_basic();
        run_frame(18, -1, -1, -1, 1'b0);
        basic_expect();
        check_stream("basic");
        check_val("basic_pairs", pair_cnt, 8'd5);

        // payload stall of two cycles between A1 and A2
        pq.delete();
        pq.push_back(10'h0A1); pq.push_back(10'h100); pq.push_back(10'h100);
        pq.push_back(10'h0A2); pq.push_back(10'h2A3);
        run_frame(20, -1, -1, -1, 1'b0);
        exp_q.delete();
        e_hdr(5); e_pl(8'hA1); e_zero(2); e_pl(8'hA2); e_pl(8'hA3); e_zero(2); e_done(); e_idle(2);
        check_stream("stall");

        // start during HDR and during PAYLOAD is ignored
        load_basic();
        run_frame(18, 3, 11, -1, 1'b0);
        basic_expect();
        check_stream("start_busy");

        // reset during the third header pair
        load_basic();
        run_frame(8, -1, -1, 4, 1'b0);
        exp_q.delete();
        e_hdr(2); exp_q.push_back(11'h555); e_idle(3);
        check_stream("rst_abort");
        check_val("rst_abort_pairs", pair_cnt, 8'd0);

        // full frame after the abort
        load_basic();
        run_frame(18, -1, -1, -1, 1'b0);
        basic_expect();
        check_stream("after_rst");
        check_val("after_rst_pairs", pair_cnt, 8'd5);

        // back-to-back frames, 1-byte payloads; 0xD5 payload passes through
        pq.delete();
        pq.push_back(10'h2B1); pq.push_back(10'h2D5);
        run_frame(29, -1, -1, -1, 1'b1);
        exp_q.delete();
        e_hdr(5); e_pl(8'hB1); e_zero(2); e_done();
        e_hdr(5); e_pl(8'hD5); e_zero(2); e_done(); e_idle(1);
        check_stream("b2b");

        // HDR_PAIRS=1, GAP_CYCLES=1 instance; 0x55 payload passes through
        sel = 1'b1;
        pq.delete();
        pq.push_back(10'h255);
        run_frame(6, -1, -1, -1, 1'b0);
        exp_q.delete();
        e_hdr(1); e_pl(8'h55); e_zero(1); e_done(); e_idle(1);
        check_stream("min");
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
